// File: rtl/seq_counter_pkg.sv
// seq_counter_pkg
//   Shared constants and types for the multi-mode sequence counter.
//   - Mode encodings for the M input (binary, Gray, Johnson, modulo).
//   - Direction encodings for the X input.
package seq_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BIN  = 2'b00;
  localparam mode_t MODE_GRAY = 2'b01;
  localparam mode_t MODE_JOHN = 2'b10;
  localparam mode_t MODE_MOD  = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/seq_counter_if.sv
// seq_counter_if
//   Control/data bundle between a driver and the sequence counter.
//   Signals:
//     EN  count enable              LD  synchronous load of D
//     D   load value (WIDTH bits)   X   direction, 0 up / 1 down
//     M   mode select (2 bits)      Q   registered count (WIDTH bits)
//     Y   registered terminal-state flag
//   Modports:
//     master - drives EN/LD/D/X/M, observes Q/Y
//     slave  - the counter side
interface seq_counter_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             EN;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic             X;
  logic [1:0]       M;
  logic [WIDTH-1:0] Q;
  logic             Y;

  modport master (
    output EN, LD, D, X, M,
    input  Q, Y
  );

  modport slave (
    input  EN, LD, D, X, M,
    output Q, Y
  );

endinterface

// File: rtl/seq_counter_next.sv
// seq_counter_next
//   Purely combinational next-state and terminal-detect function.
//   Given a candidate state (b_i, q_i), optionally advances it one step in
//   direction dir_i, derives the output pattern for the mode, and flags
//   whether the resulting state is the last one before wrap in dir_i.
//   Ports:
//     mode_i  counter mode (see seq_counter_pkg)
//     dir_i   direction, DIR_UP / DIR_DN
//     step_i  1: advance one state, 0: pass the candidate through
//     b_i     index state (binary, Gray, modulo modes)
//     q_i     pattern state (Johnson mode)
//     b_o     resulting index
//     q_o     resulting output pattern
//     term_o  resulting state is terminal in direction dir_i
module seq_counter_next
  import seq_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  mode_t            mode_i,
  input  logic             dir_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] q_o,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] One        = WIDTH'(1);
  localparam logic [WIDTH-1:0] IdxLast    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ModLast    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] JohnUpLast = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] JohnDnLast = WIDTH'(1);

  logic [WIDTH-1:0] b_up;
  logic [WIDTH-1:0] b_dn;
  logic [WIDTH-1:0] q_john;

  // Index successors; modulo mode wraps at MODULUS instead of 2**WIDTH.
  always_comb begin
    b_up = b_i + One;
    b_dn = b_i - One;
    if (mode_i == MODE_MOD) begin
      b_up = (b_i == ModLast) ? '0 : b_i + One;
      b_dn = (b_i == '0) ? ModLast : b_i - One;
    end
  end

  // Johnson ring: shift toward MSB going up, toward LSB going down, feeding
  // back the inverted bit that falls off the other end.
  always_comb begin
    if (dir_i == DIR_DN) begin
      q_john = {~q_i[0], q_i[WIDTH-1:1]};
    end else begin
      q_john = {q_i[WIDTH-2:0], ~q_i[WIDTH-1]};
    end
  end

  always_comb begin
    b_o    = b_i;
    q_o    = q_i;
    term_o = 1'b0;

    // The index is frozen in Johnson mode; only Q carries state there.
    if (step_i && (mode_i != MODE_JOHN)) begin
      b_o = (dir_i == DIR_DN) ? b_dn : b_up;
    end

    case (mode_i)
      MODE_BIN:  q_o = b_o;
      MODE_GRAY: q_o = b_o ^ (b_o >> 1);
      MODE_JOHN: q_o = step_i ? q_john : q_i;
      MODE_MOD:  q_o = b_o;
      default:   q_o = b_o;
    endcase

    case (mode_i)
      MODE_JOHN: term_o = (dir_i == DIR_DN) ? (q_o == JohnDnLast) : (q_o == JohnUpLast);
      MODE_MOD:  term_o = (dir_i == DIR_DN) ? (b_o == '0) : (b_o == ModLast);
      default:   term_o = (dir_i == DIR_DN) ? (b_o == '0) : (b_o == IdxLast);
    endcase
  end

endmodule

// File: rtl/seq_counter.sv
// seq_counter
//   Parametrised multi-mode synchronous sequence counter. Counts up or down
//   (X) in binary, Gray, Johnson or modulo-MODULUS sequence (M), with a
//   synchronous load (LD/D) and a registered terminal-state flag (Y).
//   Priority per edge: CLR > mode change > LD > EN > hold.
//   Parameters:
//     WIDTH    state/output width, 2..16
//     MODULUS  wrap count in modulo mode, 2..2**WIDTH
//   Ports:
//     clk  rising-edge clock
//     CLR  synchronous active-high clear
//     bus  seq_counter_if.slave: EN, LD, D, X, M in; Q, Y out (registered)
module seq_counter
  import seq_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input logic          clk,
  input logic          CLR,
  seq_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ModLast = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             y_q, y_d;
  mode_t            m_q, m_d;

  logic [WIDTH-1:0] load_b;
  logic [WIDTH-1:0] nx_b_in;
  logic [WIDTH-1:0] nx_q_in;
  logic             nx_step;
  logic [WIDTH-1:0] nx_b;
  logic [WIDTH-1:0] nx_q;
  logic             nx_term;

  // Out-of-range loads in modulo mode saturate to the last legal index.
  always_comb begin
    load_b = bus.D;
    if ((m_q == MODE_MOD) && (32'(bus.D) >= MODULUS)) begin
      load_b = ModLast;
    end
  end

  // Pick the candidate fed to the next-state function: the loaded value
  // (unstepped), the current state stepped, or the current state held.
  // Holding still passes through it so Y tracks the present X.
  always_comb begin
    nx_b_in = b_q;
    nx_q_in = q_q;
    nx_step = 1'b0;
    if (bus.LD) begin
      nx_b_in = load_b;
      nx_q_in = bus.D;
    end else if (bus.EN) begin
      nx_step = 1'b1;
    end
  end

  seq_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .mode_i (m_q),
    .dir_i  (bus.X),
    .step_i (nx_step),
    .b_i    (nx_b_in),
    .q_i    (nx_q_in),
    .b_o    (nx_b),
    .q_o    (nx_q),
    .term_o (nx_term)
  );

  // A mode change restarts the sequence from zero and swallows LD/EN.
  always_comb begin
    m_d = m_q;
    b_d = nx_b;
    q_d = nx_q;
    y_d = nx_term;
    if (bus.M != m_q) begin
      m_d = bus.M;
      b_d = '0;
      q_d = '0;
      y_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      b_q <= '0;
      q_q <= '0;
      y_q <= 1'b0;
      m_q <= MODE_BIN;
    end else begin
      b_q <= b_d;
      q_q <= q_d;
      y_q <= y_d;
      m_q <= m_d;
    end
  end

  assign bus.Q = q_q;
  assign bus.Y = y_q;

endmodule

// File: tb/tb_seq_counter.sv
// tb_seq_counter
//   Directed, table-driven bench for seq_counter at WIDTH=4, MODULUS=10.
//   Each record is one clock edge: the inputs held across it and the Q/Y
//   expected just after it. Multi-cycle corner cases follow as hand-written
//   sequences.
module tb_seq_counter;
  import seq_counter_pkg::*;

  localparam int unsigned W = 4;

  typedef struct {
    logic       clr;
    logic       en;
    logic       ld;
    logic [3:0] d;
    logic       x;
    logic [1:0] m;
    logic [3:0] q;
    logic       y;
  } vec_t;

  logic clk = 1'b0;
  logic CLR;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  logic [3:0] gray_tab [15] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111,
                                4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [3:0] john_up [8]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] john_dn [8]   = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};

  always #5 clk = ~clk;

  seq_counter_if #(.WIDTH(W)) bus ();

  seq_counter #(
    .WIDTH   (W),
    .MODULUS (10)
  ) dut (
    .clk (clk),
    .CLR (CLR),
    .bus (bus)
  );

  function automatic void add(input logic clr, input logic en, input logic ld,
                              input logic [3:0] d, input logic x, input logic [1:0] m,
                              input logic [3:0] q, input logic y);
    vec_t v;
    v.clr = clr; v.en = en; v.ld = ld; v.d = d; v.x = x; v.m = m; v.q = q; v.y = y;
    vecs.push_back(v);
  endfunction

  // Drive inputs, take one rising edge, sample 1 ns later and compare.
  task automatic step_check(input logic clr, input logic en, input logic ld,
                            input logic [3:0] d, input logic x, input logic [1:0] m,
                            input logic [3:0] q, input logic y, input string name);
    CLR    = clr;
    bus.EN = en;
    bus.LD = ld;
    bus.D  = d;
    bus.X  = x;
    bus.M  = m;
    @(posedge clk);
    #1;
    checks++;
    if (bus.Q !== q || bus.Y !== y) begin
      errors++;
      $display("FAIL %s: got Q=%b Y=%b, expected Q=%b Y=%b", name, bus.Q, bus.Y, q, y);
    end
  endtask

  initial begin
    CLR = 1'b0; bus.EN = 1'b0; bus.LD = 1'b0; bus.D = '0; bus.X = 1'b0; bus.M = MODE_BIN;

    // Reset.
    add(1, 0, 0, 4'd0, DIR_UP, MODE_BIN, 4'd0, 0);
    // Binary up 16 edges, then down back to 0.
    for (int i = 1; i <= 16; i++) add(0, 1, 0, 4'd0, DIR_UP, MODE_BIN, 4'(i), i == 15);
    for (int i = 15; i >= 0; i--) add(0, 1, 0, 4'd0, DIR_DN, MODE_BIN, 4'(i), i == 0);
    // Hold: Y follows X on every edge.
    add(0, 0, 0, 4'd0, DIR_DN, MODE_BIN, 4'd0, 1);
    add(0, 0, 0, 4'd0, DIR_UP, MODE_BIN, 4'd0, 0);
    // Gray: mode-change edge ignores EN, then 15 steps and the wrap.
    add(0, 1, 0, 4'd0, DIR_UP, MODE_GRAY, 4'd0, 0);
    for (int i = 0; i < 15; i++) add(0, 1, 0, 4'd0, DIR_UP, MODE_GRAY, gray_tab[i], i == 14);
    add(0, 1, 0, 4'd0, DIR_UP, MODE_GRAY, 4'd0, 0);
    // Johnson up one period, then down one period.
    add(0, 1, 0, 4'd0, DIR_UP, MODE_JOHN, 4'd0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 4'd0, DIR_UP, MODE_JOHN, john_up[i], i == 6);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 4'd0, DIR_DN, MODE_JOHN, john_dn[i], i == 6);
    // Modulo: mode change forces Y=0 even at a down-terminal state.
    add(0, 0, 0, 4'd0, DIR_DN, MODE_MOD, 4'd0, 0);
    add(0, 0, 1, 4'd3, DIR_DN, MODE_MOD, 4'd3, 0);
    add(0, 1, 0, 4'd0, DIR_DN, MODE_MOD, 4'd2, 0);
    add(0, 1, 0, 4'd0, DIR_DN, MODE_MOD, 4'd1, 0);
    add(0, 1, 0, 4'd0, DIR_DN, MODE_MOD, 4'd0, 1);
    add(0, 1, 0, 4'd0, DIR_DN, MODE_MOD, 4'd9, 0);
    add(0, 0, 1, 4'd12, DIR_DN, MODE_MOD, 4'd9, 0);  // clamped load
    add(0, 1, 1, 4'd5, DIR_DN, MODE_MOD, 4'd5, 0);   // load beats enable
    add(0, 1, 0, 4'd0, DIR_UP, MODE_MOD, 4'd6, 0);
    add(0, 1, 0, 4'd0, DIR_UP, MODE_MOD, 4'd7, 0);
    add(0, 1, 0, 4'd0, DIR_UP, MODE_MOD, 4'd8, 0);
    add(0, 1, 0, 4'd0, DIR_UP, MODE_MOD, 4'd9, 1);
    add(0, 1, 0, 4'd0, DIR_UP, MODE_MOD, 4'd0, 0);
    add(0, 0, 1, 4'd9, DIR_UP, MODE_MOD, 4'd9, 1);   // loaded terminal sets Y
    add(0, 0, 1, 4'd15, DIR_DN, MODE_MOD, 4'd9, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step_check(vecs[i].clr, vecs[i].en, vecs[i].ld, vecs[i].d, vecs[i].x, vecs[i].m,
                 vecs[i].q, vecs[i].y, $sformatf("vec%0d", i));
    end

    // Mode change mid-count swallows a simultaneous load.
    step_check(0, 0, 0, 4'd0, DIR_UP, MODE_BIN, 4'd0, 0, "mc_enter_bin");
    for (int i = 1; i <= 5; i++) begin
      step_check(0, 1, 0, 4'd0, DIR_UP, MODE_BIN, 4'(i), 0, $sformatf("mc_count%0d", i));
    end
    step_check(0, 1, 1, 4'b0111, DIR_UP, MODE_JOHN, 4'd0, 0, "mc_load_ignored");
    step_check(0, 0, 1, 4'b0111, DIR_UP, MODE_JOHN, 4'b0111, 0, "mc_load_raw");
    step_check(0, 1, 0, 4'd0, DIR_UP, MODE_JOHN, 4'b1111, 0, "mc_john_step");

    // CLR mid-count, then counting resumes from zero.
    step_check(0, 0, 0, 4'd0, DIR_UP, MODE_BIN, 4'd0, 0, "rst_enter_bin");
    for (int i = 1; i <= 6; i++) begin
      step_check(0, 1, 0, 4'd0, DIR_UP, MODE_BIN, 4'(i), 0, $sformatf("rst_count%0d", i));
    end
    step_check(1, 1, 0, 4'd0, DIR_UP, MODE_BIN, 4'd0, 0, "rst_clear");
    step_check(0, 1, 0, 4'd0, DIR_UP, MODE_BIN, 4'd1, 0, "rst_resume");

    // CLR beats load and mode; the cleared mode register makes the next
    // edge a mode change.
    step_check(1, 1, 1, 4'b1010, DIR_UP, MODE_JOHN, 4'd0, 0, "clr_over_ld");
    step_check(0, 0, 1, 4'b1010, DIR_UP, MODE_JOHN, 4'd0, 0, "clr_mode_cleared");
    step_check(0, 0, 1, 4'b1010, DIR_UP, MODE_JOHN, 4'b1010, 0, "clr_then_load");

    // Binary load at terminal, then wrap.
    step_check(0, 0, 0, 4'd0, DIR_UP, MODE_BIN, 4'd0, 0, "bin_enter");
    step_check(0, 0, 1, 4'd15, DIR_UP, MODE_BIN, 4'd15, 1, "bin_load_term");
    step_check(0, 1, 0, 4'd0, DIR_UP, MODE_BIN, 4'd0, 0, "bin_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
